// File: rtl/voxel_region_reader.sv
// -----------------------------------------------------------------------------
// voxel_region_reader
//   Read-side initiator for the 64^3 voxel store. Accepts an inclusive,
//   axis-aligned box command and visits every voxel in it, z fastest, then y,
//   then x. For each voxel it issues a read on the store port, which has a
//   1-cycle read latency. The returned words go out in order on a valid/ready
//   stream. A small return FIFO absorbs consumer backpressure. Reads are
//   issued only when the FIFO is certain to have room for the returned word.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      box command handshake (ready only while idle)
//   cmd_{x,y,z}{0,1}           inclusive lower / upper corners
//   mem_read_en/addr           read strobe and {x,y,z} address to the store
//   mem_read_data              store data, valid the cycle after mem_read_en
//   out_valid/ready            result stream handshake
//   out_data/addr/last         voxel word, its address, final-voxel flag
//   done                       one-cycle pulse once the box is fully delivered
//   vox_count                  words delivered for the current/last box
// -----------------------------------------------------------------------------
module voxel_region_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_x0,
  input  logic [5:0]  cmd_y0,
  input  logic [5:0]  cmd_z0,
  input  logic [5:0]  cmd_x1,
  input  logic [5:0]  cmd_y1,
  input  logic [5:0]  cmd_z1,
  output logic [17:0] mem_read_addr,
  output logic        mem_read_en,
  input  logic [63:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [17:0] out_addr,
  output logic        out_last,
  output logic        done,
  output logic [18:0] vox_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
  logic [5:0]  x0_d, y0_d, z0_d, x1_d, y1_d, z1_d;
  logic [5:0]  cx_q, cy_q, cz_q, cx_d, cy_d, cz_d;
  logic        inflight_q, inflight_d;
  logic [17:0] infl_addr_q, infl_addr_d;
  logic        infl_last_q, infl_last_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [18:0] vox_count_q, vox_count_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        done_q, done_d;

  logic [63:0] fifo_data_q [FIFO_DEPTH];
  logic [17:0] fifo_addr_q [FIFO_DEPTH];
  logic        fifo_last_q [FIFO_DEPTH];

  logic        credit_s;
  logic        issue_s;
  logic        push_s;
  logic        pop_s;
  logic        at_end_s;
  logic        bad_box_s;
  logic [17:0] cur_addr_s;

  // A read may only be issued if the FIFO can hold every word already owed to it.
  assign credit_s   = (count_q + {{(CW-1){1'b0}}, inflight_q}) < DEPTH_C;
  assign issue_s    = (state_q == ST_ISSUE) && credit_s;
  assign push_s     = inflight_q;
  assign pop_s      = (count_q != {CW{1'b0}}) && out_ready;
  assign cur_addr_s = {cx_q, cy_q, cz_q};
  assign at_end_s   = (cx_q == x1_q) && (cy_q == y1_q) && (cz_q == z1_q);
  assign bad_box_s  = (cmd_x1 < cmd_x0) || (cmd_y1 < cmd_y0) || (cmd_z1 < cmd_z0);

  assign mem_read_en   = issue_s;
  assign mem_read_addr = issue_s ? cur_addr_s : 18'd0;
  assign out_valid     = (count_q != {CW{1'b0}});
  assign out_data      = out_valid ? fifo_data_q[rd_ptr_q] : 64'd0;
  assign out_addr      = out_valid ? fifo_addr_q[rd_ptr_q] : 18'd0;
  assign out_last      = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  assign cmd_ready     = cmd_ready_q;
  assign done          = done_q;
  assign vox_count     = vox_count_q;

  // Next-state computation for the FSM, cursor, return tag, FIFO pointers and counter.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    z0_d        = z0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    z1_d        = z1_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    cz_d        = cz_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;

    inflight_d  = issue_s;
    infl_addr_d = issue_s ? cur_addr_s : infl_addr_q;
    infl_last_d = issue_s && at_end_s;

    wr_ptr_d    = push_s ? (wr_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d    = pop_s  ? (rd_ptr_q + {{(PW-1){1'b0}}, 1'b1}) : rd_ptr_q;
    count_d     = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    vox_count_d = pop_s ? (vox_count_q + 19'd1) : vox_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          x0_d        = cmd_x0;
          y0_d        = cmd_y0;
          z0_d        = cmd_z0;
          x1_d        = cmd_x1;
          y1_d        = cmd_y1;
          z1_d        = cmd_z1;
          cx_d        = cmd_x0;
          cy_d        = cmd_y0;
          cz_d        = cmd_z0;
          vox_count_d = 19'd0;
          cmd_ready_d = 1'b0;
          if (bad_box_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s) begin
          if (at_end_s) begin
            state_d = ST_DRAIN;
          end else if (cz_q == z1_q) begin
            // Bounds are compared before incrementing, so no 6-bit cursor wraps.
            cz_d = z0_q;
            if (cy_q == y1_q) begin
              cy_d = y0_q;
              cx_d = cx_q + 6'd1;
            end else begin
              cy_d = cy_q + 6'd1;
            end
          end else begin
            cz_d = cz_q + 6'd1;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // Look ahead through this cycle's pop so done follows the last word immediately.
        if (!inflight_q && ((count_q == {CW{1'b0}}) ||
                            ((count_q == {{(CW-1){1'b0}}, 1'b1}) && pop_s))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State registers and return FIFO storage; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x0_q        <= 6'd0;
      y0_q        <= 6'd0;
      z0_q        <= 6'd0;
      x1_q        <= 6'd0;
      y1_q        <= 6'd0;
      z1_q        <= 6'd0;
      cx_q        <= 6'd0;
      cy_q        <= 6'd0;
      cz_q        <= 6'd0;
      inflight_q  <= 1'b0;
      infl_addr_q <= 18'd0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      vox_count_q <= 19'd0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= 64'd0;
        fifo_addr_q[i] <= 18'd0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      z0_q        <= z0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      z1_q        <= z1_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      cz_q        <= cz_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      vox_count_q <= vox_count_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= mem_read_data;
        fifo_addr_q[wr_ptr_q] <= infl_addr_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
      end
    end
  end

endmodule

// File: tb/tb_voxel_region_reader.sv
module tb_voxel_region_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_x0, cmd_y0, cmd_z0, cmd_x1, cmd_y1, cmd_z1;
  logic [17:0] mem_read_addr;
  logic        mem_read_en;
  logic [63:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [17:0] out_addr;
  logic        out_last;
  logic        done;
  logic [18:0] vox_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Monitor records (reads issued, words popped), indexed from per-test bases.
  logic [17:0] rd_addr [512];
  int          rd_cyc  [512];
  int          rd_n = 0;
  logic [17:0] o_addr  [512];
  logic [63:0] o_data  [512];
  logic        o_last  [512];
  int          o_cyc   [512];
  int          out_n = 0;

  voxel_region_reader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_z0(cmd_z0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_z1(cmd_z1),
    .mem_read_addr(mem_read_addr), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .done(done), .vox_count(vox_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_data(input logic [17:0] a);
    return 64'hC0DE_0000_0000_0000 | {46'd0, a};
  endfunction

  // Voxel store model: 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_read_en === 1'b1) mem_read_data <= exp_data(mem_read_addr);
  end

  // Sample DUT activity mid-cycle.
  always @(negedge clk) begin
    if (mem_read_en === 1'b1 && rd_n < 512) begin
      rd_addr[rd_n] = mem_read_addr;
      rd_cyc[rd_n]  = cyc;
      rd_n = rd_n + 1;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && out_n < 512) begin
      o_addr[out_n] = out_addr;
      o_data[out_n] = out_data;
      o_last[out_n] = out_last;
      o_cyc[out_n]  = cyc;
      out_n = out_n + 1;
    end
  end

  task automatic send_cmd(input logic [5:0] x0, input logic [5:0] y0, input logic [5:0] z0,
                          input logic [5:0] x1, input logic [5:0] y1, input logic [5:0] z1,
                          output int t);
    @(posedge clk); #1;
    cmd_x0 = x0; cmd_y0 = y0; cmd_z0 = z0;
    cmd_x1 = x1; cmd_y1 = y1; cmd_z1 = z1;
    cmd_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int dc);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, mem_read_en, out_valid, out_last, done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {cmd_ready, mem_read_en, out_valid, out_last, done});
    end
    checks++;
    if ({vox_count, out_addr, mem_read_addr} !== 55'd0) begin
      failures++;
      $display("FAIL reset_counts got vox=%0d out_addr=%0h rd_addr=%0h exp=0", vox_count, out_addr, mem_read_addr);
    end
    checks++;
    if (out_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_data got=%0h exp=0", out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int t, dc, rb, ob;
    bit ok;
    rb = rd_n; ob = out_n;
    out_ready = 1'b1;
    send_cmd(6'd5, 6'd6, 6'd7, 6'd5, 6'd6, 6'd7, t);
    wait_done(50, ok, dc);
    checks++;
    if (!ok || dc != t + 4) begin
      failures++;
      $display("FAIL single_done_cycle got=%0d exp=%0d", dc - t, 4);
    end
    checks++;
    if (rd_n - rb != 1 || rd_addr[rb] !== 18'h05187 || rd_cyc[rb] != t + 1) begin
      failures++;
      $display("FAIL single_read got n=%0d addr=%0h at=T+%0d exp n=1 addr=05187 at=T+1", rd_n - rb, rd_addr[rb], rd_cyc[rb] - t);
    end
    checks++;
    if (out_n - ob != 1 || o_cyc[ob] != t + 3 || o_last[ob] !== 1'b1 || o_addr[ob] !== 18'h05187) begin
      failures++;
      $display("FAIL single_word got n=%0d at=T+%0d last=%b addr=%0h exp n=1 at=T+3 last=1 addr=05187", out_n - ob, o_cyc[ob] - t, o_last[ob], o_addr[ob]);
    end
    checks++;
    if (o_data[ob] !== 64'hC0DE_0000_0000_5187) begin
      failures++;
      $display("FAIL single_data got=%0h exp=c0de000000005187", o_data[ob]);
    end
    checks++;
    if (vox_count !== 19'd1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", vox_count);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_after_done got done=%b ready=%b exp done=0 ready=1", done, cmd_ready);
    end
  endtask

  task automatic test_cube2();
    logic [17:0] exp_a [8];
    int t, dc, rb, ob;
    bit ok;
    exp_a[0] = 18'h00000; exp_a[1] = 18'h00001; exp_a[2] = 18'h00040; exp_a[3] = 18'h00041;
    exp_a[4] = 18'h01000; exp_a[5] = 18'h01001; exp_a[6] = 18'h01040; exp_a[7] = 18'h01041;
    rb = rd_n; ob = out_n;
    out_ready = 1'b1;
    send_cmd(6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, t);
    wait_done(60, ok, dc);
    checks++;
    if (!ok || dc != t + 11) begin
      failures++;
      $display("FAIL cube2_done_cycle got=T+%0d exp=T+11", dc - t);
    end
    checks++;
    if (rd_n - rb != 8 || out_n - ob != 8) begin
      failures++;
      $display("FAIL cube2_counts got reads=%0d words=%0d exp 8/8", rd_n - rb, out_n - ob);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_addr[rb+i] !== exp_a[i] || rd_cyc[rb+i] != t + 1 + i) begin
        failures++;
        $display("FAIL cube2_read[%0d] got addr=%0h at=T+%0d exp addr=%0h at=T+%0d", i, rd_addr[rb+i], rd_cyc[rb+i] - t, exp_a[i], 1 + i);
      end
      checks++;
      if (o_addr[ob+i] !== exp_a[i] || o_data[ob+i] !== exp_data(exp_a[i]) ||
          o_last[ob+i] !== (i == 7) || o_cyc[ob+i] != t + 3 + i) begin
        failures++;
        $display("FAIL cube2_word[%0d] got addr=%0h data=%0h last=%b at=T+%0d exp addr=%0h last=%0d at=T+%0d", i, o_addr[ob+i], o_data[ob+i], o_last[ob+i], o_cyc[ob+i] - t, exp_a[i], (i == 7), 3 + i);
      end
    end
    checks++;
    if (vox_count !== 19'd8) begin
      failures++;
      $display("FAIL cube2_vox_count got=%0d exp=8", vox_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [17:0] exp_a [8];
    int t, dc, rb, ob;
    bit ok;
    exp_a[0] = 18'h00000; exp_a[1] = 18'h00001; exp_a[2] = 18'h00040; exp_a[3] = 18'h00041;
    exp_a[4] = 18'h01000; exp_a[5] = 18'h01001; exp_a[6] = 18'h01040; exp_a[7] = 18'h01041;
    rb = rd_n; ob = out_n;
    out_ready = 1'b0;
    send_cmd(6'd0, 6'd0, 6'd0, 6'd1, 6'd1, 6'd1, t);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rd_n - rb != 4 || out_n - ob != 0) begin
      failures++;
      $display("FAIL bp_stall got reads=%0d words=%0d exp 4/0", rd_n - rb, out_n - ob);
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 18'h00000 || out_data !== exp_data(18'h00000)) begin
      failures++;
      $display("FAIL bp_head got valid=%b addr=%0h data=%0h exp valid=1 addr=0", out_valid, out_addr, out_data);
    end
    // A command offered while busy must be ignored.
    cmd_x0 = 6'd9; cmd_y0 = 6'd9; cmd_z0 = 6'd9; cmd_x1 = 6'd9; cmd_y1 = 6'd9; cmd_z1 = 6'd9;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_busy_ready got=%b exp=0", cmd_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (rd_n - rb != 4) begin
      failures++;
      $display("FAIL bp_busy_reads got=%0d exp=4", rd_n - rb);
    end
    out_ready = 1'b1;
    wait_done(80, ok, dc);
    checks++;
    if (!ok || rd_n - rb != 8 || out_n - ob != 8) begin
      failures++;
      $display("FAIL bp_resume got done=%b reads=%0d words=%0d exp 1/8/8", ok, rd_n - rb, out_n - ob);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_addr[ob+i] !== exp_a[i] || o_data[ob+i] !== exp_data(exp_a[i]) || o_last[ob+i] !== (i == 7)) begin
        failures++;
        $display("FAIL bp_word[%0d] got addr=%0h data=%0h last=%b exp addr=%0h", i, o_addr[ob+i], o_data[ob+i], o_last[ob+i], exp_a[i]);
      end
    end
    checks++;
    if (vox_count !== 19'd8) begin
      failures++;
      $display("FAIL bp_vox_count got=%0d exp=8", vox_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inverted();
    int t, rb;
    rb = rd_n;
    out_ready = 1'b1;
    send_cmd(6'd3, 6'd0, 6'd0, 6'd2, 6'd5, 6'd5, t);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL inv_T1 got done=%b ready=%b exp done=1 ready=0", done, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || vox_count !== 19'd0) begin
      failures++;
      $display("FAIL inv_T2 got done=%b ready=%b vox=%0d exp 0/1/0", done, cmd_ready, vox_count);
    end
    checks++;
    if (rd_n != rb) begin
      failures++;
      $display("FAIL inv_no_reads got=%0d exp=0", rd_n - rb);
    end
  endtask

  task automatic test_corner();
    int t, dc, rb, ob;
    bit ok;
    rb = rd_n; ob = out_n;
    out_ready = 1'b1;
    send_cmd(6'd62, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, t);
    wait_done(50, ok, dc);
    checks++;
    if (!ok || rd_n - rb != 2 || rd_addr[rb] !== 18'h3EFFF || rd_addr[rb+1] !== 18'h3FFFF) begin
      failures++;
      $display("FAIL corner_reads got done=%b n=%0d a0=%0h a1=%0h exp 1/2/3efff/3ffff", ok, rd_n - rb, rd_addr[rb], rd_addr[rb+1]);
    end
    checks++;
    if (out_n - ob != 2 || o_last[ob] !== 1'b0 || o_last[ob+1] !== 1'b1 || o_addr[ob+1] !== 18'h3FFFF) begin
      failures++;
      $display("FAIL corner_words got n=%0d last=%b%b a1=%0h exp n=2 last=01 a1=3ffff", out_n - ob, o_last[ob], o_last[ob+1], o_addr[ob+1]);
    end
    checks++;
    if (vox_count !== 19'd2) begin
      failures++;
      $display("FAIL corner_vox_count got=%0d exp=2", vox_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int t, dc, ob, rb;
    bit ok;
    ob = out_n;
    out_ready = 1'b1;
    send_cmd(6'd0, 6'd0, 6'd0, 6'd3, 6'd3, 6'd3, t);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_n - ob >= 10) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_progress got words=%0d exp>=10", out_n - ob);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, mem_read_en, out_valid, out_last, done} !== 5'b10000 ||
        vox_count !== 19'd0 || out_data !== 64'd0 || out_addr !== 18'd0 || mem_read_addr !== 18'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got flags=%b vox=%0d data=%0h addr=%0h exp flags=10000 zeros", {cmd_ready, mem_read_en, out_valid, out_last, done}, vox_count, out_data, out_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ob = out_n; rb = rd_n;
    send_cmd(6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd3, t);
    wait_done(50, ok, dc);
    checks++;
    if (!ok || dc != t + 4 || rd_n - rb != 1) begin
      failures++;
      $display("FAIL mid_followup_done got done=%b at=T+%0d reads=%0d exp 1/T+4/1", ok, dc - t, rd_n - rb);
    end
    checks++;
    if (out_n - ob != 1 || o_addr[ob] !== 18'h01083 || o_last[ob] !== 1'b1 || o_data[ob] !== exp_data(18'h01083)) begin
      failures++;
      $display("FAIL mid_followup_word got n=%0d addr=%0h last=%b exp n=1 addr=01083 last=1", out_n - ob, o_addr[ob], o_last[ob]);
    end
    checks++;
    if (vox_count !== 19'd1) begin
      failures++;
      $display("FAIL mid_followup_count got=%0d exp=1", vox_count);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    cmd_x0 = 6'd0; cmd_y0 = 6'd0; cmd_z0 = 6'd0;
    cmd_x1 = 6'd0; cmd_y1 = 6'd0; cmd_z1 = 6'd0;
    mem_read_data = 64'd0;
    test_reset();
    test_single();
    test_cube2();
    test_backpressure();
    test_inverted();
    test_corner();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
